regbank_alu_interface: RTL and testbench

// - Couples an 8x32-bit register bank with a 32-bit ALU.
// - The 3-bit func code selects one fixed register-to-register operation: Rd <- A op B.
// - That operation executes once per rising clk edge.
// - Top-level datapath block; internal bank instance is named Bnk, holding vector reg_bank[255:0].
// - reg_bank[32*i+31:32*i] = r_i; benches probe this path hierarchically.

---
 rtl/regbank_alu_interface.sv | 82 ++++++++
 tb/tb_regbank_alu_interface.sv | 116 +++++++++++
 2 files changed

// File: rtl/regbank_alu_interface.sv
// regbank_alu_interface: 8x32 register bank coupled to a 32-bit ALU, Rd <- A op B every edge (REGBANK_DEBUG_EN adds dbg_bank/dbg_we)
module regbank_alu_interface_bank (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   waddr,
  input  logic [31:0]  wdata,
  input  logic [2:0]   raddr1,
  input  logic [2:0]   raddr2,
  output logic [31:0]  rdata1,
  output logic [31:0]  rdata2
`ifdef REGBANK_DEBUG_EN
  ,
  output logic [255:0] bank
`endif
);
  localparam logic [255:0] INIT = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  logic [255:0] reg_bank_q, reg_bank_d, reg_bank;
  assign reg_bank = reg_bank_q;
  assign rdata1 = reg_bank_q[{raddr1, 5'd0} +: 32];
  assign rdata2 = reg_bank_q[{raddr2, 5'd0} +: 32];
`ifdef REGBANK_DEBUG_EN
  assign bank = reg_bank_q;
`endif
  // next bank: only the destination word takes the ALU result
  always_comb begin
    reg_bank_d = reg_bank_q;
    reg_bank_d[{waddr, 5'd0} +: 32] = wdata;
  end
  // bank state; reset restores r_i = i immediately
  always_ff @(posedge clk or posedge rst) begin
    if (rst) reg_bank_q <= INIT;
    else     reg_bank_q <= reg_bank_d;
  end
endmodule

module regbank_alu_interface (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   func,
  output logic [31:0]  A,
  output logic [31:0]  B,
  output logic [31:0]  Z
`ifdef REGBANK_DEBUG_EN
  ,
  output logic [255:0] dbg_bank,
  output logic         dbg_we
`endif
);
  logic [2:0] src1, src2;
  assign src1 = func + 3'd1;
  assign src2 = func + 3'd2;
  regbank_alu_interface_bank Bnk (
    .clk    (clk),
    .rst    (rst),
    .waddr  (func),
    .wdata  (Z),
    .raddr1 (src1),
    .raddr2 (src2),
    .rdata1 (A),
    .rdata2 (B)
`ifdef REGBANK_DEBUG_EN
    ,
    .bank   (dbg_bank)
`endif
  );
`ifdef REGBANK_DEBUG_EN
  assign dbg_we = ~rst;
`endif
  // ALU: func picks the operation as well as the registers
  always_comb begin
    case (func)
      3'd0: Z = A + B;
      3'd1: Z = A - B;
      3'd2: Z = A & B;
      3'd3: Z = A | B;
      3'd4: Z = A ^ B;
      3'd5: Z = ~A;
      3'd6: Z = A << 1;
      3'd7: Z = A >> 1;
    endcase
  end
endmodule

// File: tb/tb_regbank_alu_interface.sv
// tb_regbank_alu_interface: directed scoreboard bench for regbank_alu_interface
module tb_regbank_alu_interface;
  logic clk = 0, rst = 0;
  logic [2:0] func = 0;
  logic [31:0] A, B, Z;
`ifdef REGBANK_DEBUG_EN
  logic [255:0] dbg_bank;
  logic dbg_we;
`endif
  int n_cmp = 0, n_err = 0;
  typedef struct { string tag; int idx; logic [31:0] val; } exp_t;
  exp_t sb[$];
  logic [31:0] seq_exp [8] = '{32'd3, 32'hFFFFFFFF, 32'd0, 32'd5, 32'd3, 32'hFFFFFFF9, 32'd14, 32'd1};
  logic [255:0] init_bank = {32'd7, 32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0};
  logic [31:0] m [8];

  regbank_alu_interface dut (
    .clk  (clk),
    .rst  (rst),
    .func (func),
    .A    (A),
    .B    (B),
    .Z    (Z)
`ifdef REGBANK_DEBUG_EN
    ,
    .dbg_bank (dbg_bank),
    .dbg_we   (dbg_we)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    case (f)
      3'd0: return a + b;
      3'd1: return a - b;
      3'd2: return a & b;
      3'd3: return a | b;
      3'd4: return a ^ b;
      3'd5: return ~a;
      3'd6: return {a[30:0], 1'b0};
      default: return {1'b0, a[31:1]};
    endcase
  endfunction

  task automatic pop_check();
    exp_t e;
    if (sb.size() == 0) begin
      n_cmp++; n_err++;
      $display("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb.pop_front();
      chk(e.tag, {224'd0, dut.Bnk.reg_bank[32*e.idx +: 32]}, {224'd0, e.val});
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) m[i] = i;
    @(negedge clk);
    rst = 1; func = 0;
    #2;
    chk("reset_bank", dut.Bnk.reg_bank, init_bank);
    chk("reset_A", {224'd0, A}, 256'd1);
    chk("reset_B", {224'd0, B}, 256'd2);
    chk("reset_Z", {224'd0, Z}, 256'd3);
`ifdef REGBANK_DEBUG_EN
    chk("reset_dbg_we", {255'd0, dbg_we}, 256'd0);
`endif
    @(negedge clk);
    rst = 0;
    for (int f = 0; f < 8; f++) begin
      func = f[2:0];
      #1;
      chk($sformatf("A_f%0d", f), {224'd0, A}, {224'd0, m[(f + 1) % 8]});
      chk($sformatf("B_f%0d", f), {224'd0, B}, {224'd0, m[(f + 2) % 8]});
      chk($sformatf("Z_f%0d", f), {224'd0, Z}, {224'd0, alu(f[2:0], m[(f + 1) % 8], m[(f + 2) % 8])});
      m[f] = alu(f[2:0], m[(f + 1) % 8], m[(f + 2) % 8]);
      sb.push_back('{$sformatf("model_r%0d", f), f, m[f]});
      sb.push_back('{$sformatf("spec_r%0d", f), f, seq_exp[f]});
      @(posedge clk); #1;
      pop_check();
      pop_check();
`ifdef REGBANK_DEBUG_EN
      chk($sformatf("dbg_bank_f%0d", f), dbg_bank, dut.Bnk.reg_bank);
      chk($sformatf("dbg_we_f%0d", f), {255'd0, dbg_we}, 256'd1);
`endif
      @(negedge clk);
    end
    chk("seq_bank", dut.Bnk.reg_bank,
        {32'd1, 32'd14, 32'hFFFFFFF9, 32'd3, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd3});
    @(posedge clk); #1;
    rst = 1;
    #1;
    chk("async_reset_bank", dut.Bnk.reg_bank, init_bank);
    @(negedge clk);
    rst = 0; func = 0;
    for (int k = 0; k < 3; k++) begin
      sb.push_back('{$sformatf("hold_r0_%0d", k), 0, 32'd3});
      @(posedge clk); #1;
      pop_check();
      chk($sformatf("hold_others_%0d", k), {32'd0, dut.Bnk.reg_bank[255:32]}, {32'd0, init_bank[255:32]});
      @(negedge clk);
    end
    chk("hold_Z", {224'd0, Z}, 256'd3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
